// File: rtl/pulpemu_clk_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// A channel configuration is the pair {divisor, enable}.
package pulpemu_clk_pkg;

  localparam int unsigned CLK_DIV_MAX_W = 32;
  localparam int unsigned CLK_DIV_MIN   = 2;

  // The divisor field is sized for the widest supported counter; narrower
  // instances zero-extend into it and synthesis trims the constant upper bits.
  typedef struct packed {
    logic [CLK_DIV_MAX_W-1:0] div;
    logic                     en;
  } clk_cfg_t;

endpackage

// File: rtl/pulpemu_clk_div_ch.sv
// One divider channel: counter, single-entry pending config slot, and the
// registered divided output with its rising-edge tick.
module pulpemu_clk_div_ch
  import pulpemu_clk_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 256,
  parameter logic        DEFAULT_EN  = 1'b1
) (
  input  logic     clk_i,
  input  logic     rstn_i,
  input  logic     cfg_we_i,
  input  clk_cfg_t cfg_i,
  output logic     pend_valid_o,
  output logic     div_o,
  output logic     tick_o
);

  localparam clk_cfg_t RST_CFG = '{div: CLK_DIV_MAX_W'(DEFAULT_DIV), en: DEFAULT_EN};

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  clk_cfg_t             act_q, act_d;
  clk_cfg_t             pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 div_q, div_d;
  logic                 div_prev_q;
  logic                 wrap;

  always_comb begin
    cnt_d      = cnt_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    wrap       = act_q.en &&
                 (CLK_DIV_MAX_W'(cnt_q) == (act_q.div - CLK_DIV_MAX_W'(1)));

    if (!act_q.en) begin
      // Idle channel: nothing to protect, apply immediately from cnt 0.
      if (cfg_we_i) begin
        act_d = cfg_i;
        cnt_d = '0;
      end
    end else if (wrap) begin
      cnt_d = '0;
      if (cfg_we_i) begin
        act_d = cfg_i;
      end else if (pend_vld_q) begin
        act_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (cfg_we_i) begin
        pend_d     = cfg_i;
        pend_vld_d = 1'b1;
      end
    end

    // Output is decoded from next-state so div_q lines up with cnt_q.
    div_d = act_d.en && (CLK_DIV_MAX_W'(cnt_d) >= (act_d.div >> 1));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q      <= '0;
      act_q      <= RST_CFG;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      div_q      <= 1'b0;
      div_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      div_q      <= div_d;
      div_prev_q <= div_q;
    end
  end

  assign pend_valid_o = pend_vld_q;
  assign div_o        = div_q;
  assign tick_o       = div_q & ~div_prev_q;

endmodule

// File: rtl/pulpemu_clk_div_multi.sv
// N_CH independent clock dividers behind a single valid/ready config port.
// The top only decodes the request, drives ready, and flags illegal requests.
module pulpemu_clk_div_multi
  import pulpemu_clk_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 256,
  parameter logic        DEFAULT_EN  = 1'b1,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CH_W-1:0]      cfg_ch_i,
  input  logic [CNT_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_en_i,
  output logic                 cfg_err_o,
  output logic [N_CH-1:0]      div_o,
  output logic [N_CH-1:0]      tick_o
);

  // Handshake: a request transfers on a cycle where cfg_valid_i && cfg_ready_o.
  // Ready drops only while the addressed channel already holds a pending
  // request; the requester keeps cfg_* stable until the transfer happens.

  logic [N_CH-1:0] pend_vld;
  logic [N_CH-1:0] ch_we;
  logic            ready;
  logic            accept;
  logic            legal;
  logic            err_q, err_d;
  clk_cfg_t        cfg_in;

  always_comb begin
    ready  = 1'b1;
    ch_we  = '0;
    cfg_in = '{div: CLK_DIV_MAX_W'(cfg_div_i), en: cfg_en_i};
    legal  = (CLK_DIV_MAX_W'(cfg_ch_i) < CLK_DIV_MAX_W'(N_CH)) &&
             (CLK_DIV_MAX_W'(cfg_div_i) >= CLK_DIV_MAX_W'(CLK_DIV_MIN));

    for (int c = 0; c < N_CH; c++) begin
      if ((cfg_ch_i == CH_W'(c)) && pend_vld[c]) ready = 1'b0;
    end

    accept = cfg_valid_i && ready;

    for (int c = 0; c < N_CH; c++) begin
      ch_we[c] = accept && legal && (cfg_ch_i == CH_W'(c));
    end

    err_d = accept && !legal;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign cfg_ready_o = ready;
  assign cfg_err_o   = err_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pulpemu_clk_div_ch #(
      .CNT_WIDTH  (CNT_WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV),
      .DEFAULT_EN (DEFAULT_EN)
    ) u_ch (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .cfg_we_i    (ch_we[c]),
      .cfg_i       (cfg_in),
      .pend_valid_o(pend_vld[c]),
      .div_o       (div_o[c]),
      .tick_o      (tick_o[c])
    );
  end

endmodule

// File: tb/tb_pulpemu_clk_div_multi.sv
// Directed bench for pulpemu_clk_div_multi: a vector table for default
// operation, idle-channel config and illegal requests, then hand sequences.
module tb_pulpemu_clk_div_multi;

  localparam int N_CH = 3;
  localparam int CW   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_ch;
  logic [CW-1:0]   cfg_div;
  logic            cfg_en;
  logic            cfg_err;
  logic [N_CH-1:0] div_o;
  logic [N_CH-1:0] tick_o;

  pulpemu_clk_div_multi #(
    .N_CH       (N_CH),
    .CNT_WIDTH  (CW),
    .DEFAULT_DIV(4),
    .DEFAULT_EN (1'b1)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_ch_i   (cfg_ch),
    .cfg_div_i  (cfg_div),
    .cfg_en_i   (cfg_en),
    .cfg_err_o  (cfg_err),
    .div_o      (div_o),
    .tick_o     (tick_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       vld;
    logic [1:0] ch;
    logic [7:0] dv_in;
    logic       en;
    logic       rdy;
    logic       err;
    logic [2:0] dv;
    logic [2:0] tk;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic vld, logic [1:0] ch, logic [7:0] dv_in, logic en,
                              logic rdy, logic err, logic [2:0] dv, logic [2:0] tk);
    vec_t v;
    v.vld = vld; v.ch = ch; v.dv_in = dv_in; v.en = en;
    v.rdy = rdy; v.err = err; v.dv = dv; v.tk = tk;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic drive(input logic vld, input logic [1:0] ch, input logic [7:0] dv, input logic en);
    cfg_valid = vld;
    cfg_ch    = ch;
    cfg_div   = dv;
    cfg_en    = en;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " rst div"}, 32'(div_o), 32'd0);
    chk({tag, " rst tick"}, 32'(tick_o), 32'd0);
    chk({tag, " rst err"}, 32'(cfg_err), 32'd0);
    rstn = 1'b1;
  endtask

  logic [0:21] exp_b_div0;
  logic [0:11] exp_c_div1;
  logic [0:11] exp_c_tick1;

  initial begin
    drive(1'b0, 2'd0, 8'd0, 1'b0);

    // t0: disable ch1 (pending, applies at wrap 3->4); t4: ch1 DIV=5 while idle;
    // t8: out-of-range channel; t10: divisor 1. Bit 0 = channel 0.
    vecs[0]  = mk(1'b1, 2'd1, 8'd4, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    vecs[1]  = mk(1'b0, 2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    vecs[2]  = mk(1'b0, 2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b111);
    vecs[3]  = mk(1'b0, 2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000);
    vecs[4]  = mk(1'b1, 2'd1, 8'd5, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
    vecs[5]  = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    vecs[6]  = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b101);
    vecs[7]  = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b010);
    vecs[8]  = mk(1'b1, 2'd3, 8'd4, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000);
    vecs[9]  = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'b010, 3'b000);
    vecs[10] = mk(1'b1, 2'd0, 8'd1, 1'b0, 1'b1, 1'b0, 3'b101, 3'b101);
    vecs[11] = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'b101, 3'b000);
    vecs[12] = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'b010, 3'b010);
    vecs[13] = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'b010, 3'b000);
    vecs[14] = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b101);
    vecs[15] = mk(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b000);

    exp_b_div0  = 22'b0011_0000_1111_0011_000111;
    exp_c_div1  = 12'b0011_0000_0110;
    exp_c_tick1 = 12'b0010_0000_0100;

    // table-driven vectors
    do_reset("tbl");
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].vld, vecs[i].ch, vecs[i].dv_in, vecs[i].en);
      #1;
      chk($sformatf("vec%0d ready", i), 32'(cfg_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d err", i), 32'(cfg_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d div", i), 32'(div_o), 32'(vecs[i].dv));
      chk($sformatf("vec%0d tick", i), 32'(tick_o), 32'(vecs[i].tk));
      next_cycle();
    end

    // ch0 DIV 4 -> 8, then 8 -> 4 at cnt 2, then a second request held off until the wrap
    do_reset("chg");
    for (int t = 0; t < 22; t++) begin
      if (t == 0)                drive(1'b1, 2'd0, 8'd8, 1'b1);
      else if (t == 6)           drive(1'b1, 2'd0, 8'd4, 1'b1);
      else if (t >= 7 && t <= 12) drive(1'b1, 2'd0, 8'd6, 1'b1);
      else                       drive(1'b0, 2'd0, 8'd0, 1'b0);
      #1;
      if (cfg_valid)
        chk($sformatf("chg t%0d ready", t), 32'(cfg_ready), (t >= 7 && t <= 11) ? 32'd0 : 32'd1);
      chk($sformatf("chg t%0d div0", t), 32'(div_o[0]), 32'(exp_b_div0[t]));
      chk($sformatf("chg t%0d tick0", t), 32'(tick_o[0]),
          (t == 2 || t == 8 || t == 14 || t == 19) ? 32'd1 : 32'd0);
      chk($sformatf("chg t%0d div2", t), 32'(div_o[2]), ((t % 4) >= 2) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // disable ch1 in its high phase, then re-enable
    do_reset("dis");
    for (int t = 0; t < 12; t++) begin
      if (t == 2)      drive(1'b1, 2'd1, 8'd4, 1'b0);
      else if (t == 6) drive(1'b1, 2'd1, 8'd4, 1'b1);
      else             drive(1'b0, 2'd0, 8'd0, 1'b0);
      #1;
      if (cfg_valid) chk($sformatf("dis t%0d ready", t), 32'(cfg_ready), 32'd1);
      chk($sformatf("dis t%0d div1", t), 32'(div_o[1]), 32'(exp_c_div1[t]));
      chk($sformatf("dis t%0d tick1", t), 32'(tick_o[1]), 32'(exp_c_tick1[t]));
      chk($sformatf("dis t%0d div0", t), 32'(div_o[0]), ((t % 4) >= 2) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // asynchronous reset mid-period with a pending request on ch0
    do_reset("arst");
    for (int t = 0; t < 3; t++) begin
      if (t == 0) drive(1'b1, 2'd0, 8'd8, 1'b0);
      else        drive(1'b0, 2'd0, 8'd0, 1'b0);
      #1;
      if (t == 2) begin
        chk("arst pre ready", 32'(cfg_ready), 32'd0);
        chk("arst pre div", 32'(div_o), 32'b111);
      end
      if (t < 2) next_cycle();
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("arst async div", 32'(div_o), 32'd0);
    chk("arst async tick", 32'(tick_o), 32'd0);
    chk("arst async err", 32'(cfg_err), 32'd0);
    next_cycle();
    rstn = 1'b1;
    for (int t = 0; t < 8; t++) begin
      drive(1'b0, 2'd0, 8'd0, 1'b0);
      #1;
      if (t == 0) chk("arst post ready", 32'(cfg_ready), 32'd1);
      chk($sformatf("arst t%0d div", t), 32'(div_o), ((t % 4) >= 2) ? 32'b111 : 32'b000);
      next_cycle();
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulpemu_clk_div_multi.md
PULPEMU_CLK_DIV_MULTI -- requirements
Module: pulpemu_clk_div_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_WIDTH, default 16: divisor and counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 256: divisor loaded into every channel at reset; SHALL be >= 2.
REQ-004 Parameter DEFAULT_EN, default 1'b1: enable state loaded into every channel at reset.
REQ-005 clk_i  in  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-006 rstn_i  in  1  reset; asynchronous assertion, active-low.
REQ-007 cfg_valid_i  in  1  configuration request valid.
REQ-008 cfg_ready_o  out  1  configuration request accepted this cycle when high together with cfg_valid_i.
REQ-009 cfg_ch_i  in  $clog2(N_CH) (min 1)  target channel.
REQ-010 cfg_div_i  in  CNT_WIDTH  requested divisor.
REQ-011 cfg_en_i  in  1  requested channel enable.
REQ-012 cfg_err_o  out  1  one-cycle pulse: accepted request rejected.
REQ-013 div_o  out  N_CH  divided reference outputs; registered, glitch-free.
REQ-014 tick_o  out  N_CH  one-cycle pulse in the cycle div_o[c] goes 0->1.

Function
REQ-015 Each channel SHALL hold a counter cnt (0..DIV-1), an active DIV, an active EN, and one pending slot {div, en, valid}.
REQ-016 Enabled channel: cnt increments each cycle and wraps from DIV-1 to 0; div_o[c] SHALL be 0 while cnt < floor(DIV/2), otherwise 1; output period is exactly DIV cycles.
REQ-017 Disabled channel: cnt held at 0; div_o[c] = 0; tick_o[c] = 0.
REQ-018 cfg_ready_o = 1 unless cfg_ch_i is in range and that channel's pending slot is valid.
REQ-019 Handshake occurs when cfg_valid_i && cfg_ready_o; requester SHALL hold all cfg inputs stable while valid is high and ready is low.
REQ-020 Accepted request with cfg_div_i < 2 or cfg_ch_i >= N_CH: cfg_err_o pulses the next cycle; no channel state changes.
REQ-021 Accepted legal request to a disabled channel: the new DIV/EN takes effect the next cycle with cnt = 0; the pending slot is not used.
REQ-022 Accepted legal request to an enabled channel: the request is stored in the pending slot and applied on the wrap (cnt == DIV-1 -> 0); the first cycle of the new period uses the new DIV/EN.
REQ-023 If acceptance coincides with the wrap cycle, the request SHALL apply at that same wrap.
REQ-024 A disable request therefore always completes the current full period; an output pulse SHALL never be truncated.
REQ-025 Channels SHALL be fully independent; configuring one channel SHALL NOT perturb the phase of any other channel.
REQ-026 tick_o[c] SHALL equal div_o[c] & ~div_o_prev[c], produced from registered state with no combinational path from cfg inputs.

Reset
REQ-027 On rstn_i low, every channel SHALL take: DIV = DEFAULT_DIV, EN = DEFAULT_EN, cnt = 0, pending invalid, div_o = 0, tick_o = 0; cfg_err_o = 0.
REQ-028 Reset asserted mid-period or mid-handshake SHALL discard all pending requests; after release, enabled channels start at cnt = 0.

Structure
REQ-029 Package pulpemu_clk_pkg SHALL hold the channel-config struct {div, en} and the minimum legal divisor constant (2).
REQ-030 One sub-module, pulpemu_clk_div_ch (counter, pending slot, output flop), SHALL be instantiated N_CH times; the top contains only cfg decode, ready and error logic.

Verification
REQ-031 Reset with defaults (DEFAULT_DIV = 4, DEFAULT_EN = 1) -> each div_o pattern is 0,0,1,1 repeating; tick_o pulses once per 4 cycles, in the 3rd cycle of the pattern.
REQ-032 DIV = 5 on channel 1 while disabled -> from the next cycle, low 2 cycles, high 3 cycles; channel 0 phase unchanged.
REQ-033 Change channel 0 from DIV 8 to 4 at cnt = 2 -> the old 8-cycle period completes, then 4-cycle periods follow; a second request while pending sees cfg_ready_o = 0 until the wrap.
REQ-034 cfg_div_i = 1 and cfg_ch_i = N_CH -> each request is accepted, cfg_err_o pulses once, and all outputs are unchanged.
REQ-035 Disable request during the high phase -> div_o stays high until the period ends, then stays 0; re-enable restarts at cnt = 0 the next cycle.
REQ-036 Assert rstn_i asynchronously mid-period with a pending request -> outputs go 0 immediately; after release, defaults apply and the pending request is lost.
